// File: rtl/mul_error_profiler.sv
// mul_error_profiler
// Sweeps every operand pair through a combinational multiplier-under-test,
// compares each approximate product against the exact product and keeps
// error statistics (error count, error-distance sum, worst case).
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           begin a sweep (sampled only while idle)
//   busy, done      sweep in progress / one-cycle results-final pulse
//   op_a, op_b      registered operands to the multiplier-under-test
//   prod_apx        approximate product, combinational in op_a/op_b
//   err_cnt         number of pairs with nonzero error distance
//   sum_ed          sum of |exact - approx| over all pairs
//   max_ed          largest error distance seen
//   worst_a/worst_b first pair that reached max_ed
//   fsm_state       current controller state, for observation only
//
// Handshake: start is a level sampled on a rising edge only in IDLE; the
// same edge raises busy. busy stays high until the edge that raises done.
// done is high for exactly one cycle; results are stable from that cycle
// until the next accepted start. start while not idle is ignored.
module mul_error_profiler #(
    parameter int W     = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   prod_apx,
    output logic [2*W:0]     err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t         state;
    logic [2*W-1:0] pair;       // {a, b}, b in the LSBs so b varies fastest
    logic           drain_cnt;

    // S1
    logic           v1;
    logic [2*W-1:0] apx1;
    logic [2*W-1:0] exact1;
    logic [2*W-1:0] pair1;
    // S2
    logic           v2;
    logic [2*W-1:0] ed2;
    logic [2*W-1:0] pair2;

    logic [2*W-1:0] exact;

    assign op_a      = pair[2*W-1:W];
    assign op_b      = pair[W-1:0];
    assign exact     = (2*W)'(op_a) * (2*W)'(op_b);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pair      <= '0;
            drain_cnt <= 1'b0;
            v1        <= 1'b0;
            apx1      <= '0;
            exact1    <= '0;
            pair1     <= '0;
            v2        <= 1'b0;
            ed2       <= '0;
            pair2     <= '0;
            err_cnt   <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else begin
            // S1: only cycles spent in SWEEP carry a real pair
            v1     <= (state == SWEEP);
            apx1   <= prod_apx;
            exact1 <= exact;
            pair1  <= pair;

            // S2: error distance; the approximation may overshoot
            v2     <= v1;
            ed2    <= (exact1 >= apx1) ? (exact1 - apx1) : (apx1 - exact1);
            pair2  <= pair1;

            // S3: strict compare keeps the earliest pair on ties
            if (v2) begin
                sum_ed  <= sum_ed + ACC_W'(ed2);
                err_cnt <= err_cnt + (2*W+1)'(ed2 != '0);
                if (ed2 > max_ed) begin
                    max_ed  <= ed2;
                    worst_a <= pair2[2*W-1:W];
                    worst_b <= pair2[W-1:0];
                end
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    pair <= '0;
                    if (start) begin
                        state   <= SWEEP;
                        busy    <= 1'b1;
                        err_cnt <= '0;
                        sum_ed  <= '0;
                        max_ed  <= '0;
                        worst_a <= '0;
                        worst_b <= '0;
                    end
                end
                SWEEP: begin
                    if (pair == {(2*W){1'b1}}) begin
                        state     <= DRAIN;
                        pair      <= '0;
                        drain_cnt <= 1'b0;
                    end else begin
                        pair <= pair + 1'b1;
                    end
                end
                DRAIN: begin
                    // two cycles lets the last pair leave S2 and reach S3
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_error_profiler.sv
// Bench for mul_error_profiler, run at W=4 so each full sweep is short.
// A stand-in multiplier (selected by mode) feeds prod_apx. A reference model
// derives expected results from a plain loop over all pairs and expected
// busy/done/operand timing from the sweep position counted from the start
// edge; a compare process checks every cycle. Directed sweeps pin the
// model with hand-computed results.
module tb_mul_error_profiler;

    localparam int TW    = 4;
    localparam int TACC  = 40;
    localparam int N     = 1 << (2 * TW);
    localparam int AMAX  = (1 << TW) - 1;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint wa;
        longint wb;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [TW-1:0]     op_a;
    logic [TW-1:0]     op_b;
    logic [2*TW-1:0]   prod_apx;
    logic [2*TW:0]     err_cnt;
    logic [TACC-1:0]   sum_ed;
    logic [2*TW-1:0]   max_ed;
    logic [TW-1:0]     worst_a;
    logic [TW-1:0]     worst_b;
    logic [1:0]        fsm_state;

    int          mode = 0;
    int unsigned s1 = 0, s2 = 0, s3 = 0, msk = 0;
    int          tests = 0;
    int          fails = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mul_error_profiler #(.W(TW), .ACC_W(TACC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .op_a(op_a), .op_b(op_b), .prod_apx(prod_apx), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .worst_a(worst_a),
        .worst_b(worst_b), .fsm_state(fsm_state)
    );

    // ---------------- stand-in multipliers ----------------
    function automatic logic [2*TW-1:0] apx_f(input int m, input int unsigned a,
                                              input int unsigned b, input int unsigned k1,
                                              input int unsigned k2, input int unsigned k3,
                                              input int unsigned km);
        int unsigned e;
        int unsigned r;
        e = a * b;
        case (m)
            0:       r = e;
            1:       r = e & ~32'd1;
            2:       r = e + 1;
            3:       r = 0;
            default: r = e ^ ((a * k1 + b * k2 + e * k3) & km);
        endcase
        return r[2*TW-1:0];
    endfunction

    assign prod_apx = apx_f(mode, 32'(op_a), 32'(op_b), s1, s2, s3, msk);

    // ---------------- reference model ----------------
    function automatic res_t model(input int m, input int unsigned k1, input int unsigned k2,
                                   input int unsigned k3, input int unsigned km);
        res_t r;
        longint ex, ap, ed;
        r = '{default: 0};
        for (int a = 0; a <= AMAX; a++) begin
            for (int b = 0; b <= AMAX; b++) begin
                ex = longint'(a * b);
                ap = longint'(apx_f(m, a, b, k1, k2, k3, km));
                ed = (ex > ap) ? ex - ap : ap - ex;
                r.sum += ed;
                if (ed != 0) r.err++;
                if (ed > r.mx) begin
                    r.mx = ed;
                    r.wa = a;
                    r.wb = b;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".err_cnt"}, longint'(err_cnt), e.err);
        chk({tag, ".sum_ed"},  longint'(sum_ed),  e.sum);
        chk({tag, ".max_ed"},  longint'(max_ed),  e.mx);
        chk({tag, ".worst_a"}, longint'(worst_a), e.wa);
        chk({tag, ".worst_b"}, longint'(worst_b), e.wb);
    endtask

    // ---------------- per-cycle compare process ----------------
    // k = -1 while idle, otherwise cycles since the start-sampling edge.
    int   k = -1;
    res_t hold = '{default: 0};
    res_t exp_sweep = '{default: 0};

    always @(posedge clk) begin
        if (!rst_n) begin
            k = -1;
            hold = '{default: 0};
        end else if (k < 0) begin
            if (start) begin
                k = 0;
                exp_sweep = model(mode, s1, s2, s3, msk);
                hold = '{default: 0};
            end
        end else begin
            k++;
            if (k == N + 2) hold = exp_sweep;
            if (k > N + 2) k = -1;
        end
        #1;
        chk("cyc.busy", longint'(busy), longint'(k >= 0 && k <= N + 1));
        chk("cyc.done", longint'(done), longint'(k == N + 2));
        if (k < 0) begin
            chk("cyc.op_idle", longint'({op_a, op_b}), 0);
        end else if (k < N) begin
            chk("cyc.op_pair", longint'({op_a, op_b}), longint'(k));
        end
        if (k <= 0 || k == N + 2) chk_res("cyc", hold);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns number of negedges until done is seen (first one is in the
    // cycle right after the current edge).
    task automatic wait_done(input bit noise, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ok = 1'b1;
                start = 1'b0;
                break;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk("done_seen", longint'(ok), 1);
    endtask

    task automatic run_sweep(input string tag, input int m, input bit noise, input res_t e);
        int lat;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        wait_done(noise, lat);
        chk({tag, ".latency"}, longint'(lat), longint'(N + 3));
        chk_res(tag, e);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, longint'(done), 0);
    endtask

    // ---------------- main sequence ----------------
    res_t r_exact, r_bit0, r_plus1, r_zero, r_rnd, r_m;
    int   lat;
    int   done_seen;

    initial begin
        r_exact = '{err: 0,   sum: 0,     mx: 0,   wa: 0,  wb: 0};
        r_bit0  = '{err: 64,  sum: 64,    mx: 1,   wa: 1,  wb: 1};
        r_plus1 = '{err: 256, sum: 256,   mx: 1,   wa: 0,  wb: 0};
        r_zero  = '{err: 225, sum: 14400, mx: 225, wa: 15, wb: 15};

        do_reset();
        @(negedge clk);
        chk("rst.busy", longint'(busy), 0);
        chk("rst.done", longint'(done), 0);
        chk_res("rst", '{default: 0});

        // pin the model to hand-computed figures
        r_m = model(3, 0, 0, 0, 0);
        chk("model.zero_sum", r_m.sum, r_zero.sum);
        chk("model.zero_err", r_m.err, r_zero.err);
        r_m = model(1, 0, 0, 0, 0);
        chk("model.bit0_err", r_m.err, r_bit0.err);

        run_sweep("exact", 0, 1'b0, r_exact);
        run_sweep("bit0",  1, 1'b0, r_bit0);
        run_sweep("plus1", 2, 1'b0, r_plus1);
        run_sweep("zero",  3, 1'b0, r_zero);
        run_sweep("zero_noise", 3, 1'b1, r_zero);

        // reset mid-sweep
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.busy", longint'(busy), 0);
        chk("midrst.op", longint'({op_a, op_b}), 0);
        chk_res("midrst", '{default: 0});
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst.no_done", longint'(done_seen), 0);
        run_sweep("restart", 3, 1'b0, r_zero);

        // start held high across DONE
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        done_seen = 0;
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1;
                break;
            end
        end
        chk("hold.done_seen", longint'(done_seen), 1);
        @(negedge clk);
        chk("hold.idle_busy", longint'(busy), 0);
        chk("hold.idle_err", longint'(err_cnt), 225);
        @(negedge clk);
        chk("hold.restart_busy", longint'(busy), 1);
        chk("hold.cleared_err", longint'(err_cnt), 0);
        chk("hold.cleared_sum", longint'(sum_ed), 0);
        start = 1'b0;
        wait_done(1'b0, lat);
        chk("hold.latency", longint'(lat), longint'(N + 2));
        chk_res("hold", r_zero);

        // randomized approximate multipliers
        for (int it = 0; it < 6; it++) begin
            @(negedge clk);
            s1  = $urandom;
            s2  = $urandom;
            s3  = $urandom;
            msk = $urandom_range(0, (1 << (2 * TW)) - 1);
            r_rnd = model(4, s1, s2, s3, msk);
            run_sweep("rand", 4, 1'($urandom_range(0, 1)), r_rnd);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
